led_pattern_ctrl: RTL
=====================

Name: led_pattern_ctrl

Overview:
Sequencer that drives the board LED bank with selectable display patterns, stepping once per programmable prescaler period. It sits between the top-level config source (keys/debounce or a host register) and the LED pins. It owns the prescaler, the pattern state machine and a one-deep configuration handshake. Mode changes are applied only on step boundaries so patterns never glitch mid-step.

Parameters:
LED_W, 4, number of LED outputs (>=2)
TICK_DIV, 25_000_000, clk cycles per pattern step (500 ms at 50 MHz); must be >=2
CNT_W, 25, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV

Ports:
clk  input  1  system clock, 50 MHz, 20 ns period
rst  input  1  synchronous reset, active-high
enable  input  1  1 = pattern runs; 0 = freeze prescaler and LEDs
cfg_valid  input  1  new mode offered
cfg_mode  input  2  00 OFF, 01 SHIFT, 10 BLINK, 11 COUNT
cfg_ready  output  1  1 = no config pending; accepts when cfg_valid & cfg_ready
led  output  LED_W  LED drive, 1 = lit (see optional feature)
step_pulse  output  1  one-cycle pulse on every applied step
mode  output  2  currently active mode

Behaviour:
- Reset (rst=1 at posedge): led=0, mode=OFF, state=IDLE, prescaler=0, pending flag=0, cfg_ready=1, step_pulse=0. Reset overrides every other input, including a cfg accepted in the same cycle; reset asserted mid-step discards the partial count.
- Prescaler: counts 0..TICK_DIV-1 while state=RUN and enable=1; at TICK_DIV-1 it wraps to 0 and produces an internal tick in that cycle. It holds its value when enable=0 and clears to 0 in IDLE.
- Config handshake: on cfg_valid & cfg_ready, cfg_mode is latched into pend_mode, the pending flag sets, and cfg_ready drops on the next cycle. cfg_ready returns to 1 the cycle after the pending mode is applied. cfg_valid while cfg_ready=0 is ignored, with no queueing.
- FSM states:
  - IDLE: mode=OFF, led=0. A pending config is applied the next cycle: a non-OFF mode goes to LOAD, and OFF stays in IDLE and clears the pending flag.
  - LOAD: a one-cycle state. It sets mode=pend_mode, clears the pending flag, clears the prescaler and loads the initial pattern: SHIFT gives led=...0001, BLINK gives all ones, COUNT gives 0. It then goes to RUN. step_pulse is not asserted.
  - RUN: on each tick, if the pending flag is set it applies the pending mode instead of stepping. OFF goes to IDLE with led=0. Any other mode goes to LOAD, and this includes re-selecting the same mode, which restarts the pattern. With no pending config, led advances one step and step_pulse=1 in that cycle.
- Step rules, registered with LED updating on the tick edge:
  - SHIFT: rotate left by 1; the MSB wraps to bit0.
  - BLINK: bitwise invert.
  - COUNT: led+1 modulo 2^LED_W; all-ones wraps to 0.
- A simultaneous cfg accept and tick in the same cycle latches the config only; it is applied at the following tick, not the current one.
- enable=0 in RUN freezes led, mode and prescaler. A config may still be accepted but is not applied until ticks resume. IDLE-state application is independent of enable.
- Latency: a config accepted in IDLE shows its initial pattern on led 2 cycles after the accept edge. In RUN it shows at the next tick plus 1 cycle (LOAD).

Optional Feature:
LED_ACTIVE_LOW_EN
- Defined: led is the bitwise inverse of the internal pattern, so reset/IDLE drive all ones for an active-low board.
- Undefined: led equals the internal pattern, and reset drives all zeros.
- All other outputs and timing are identical in both builds.

Test Plan:
- TICK_DIV=4. Reset held 10 cycles, then released -> led=0000, mode=00, cfg_ready=1, step_pulse never pulses.
- Accept SHIFT from IDLE, enable=1 -> led=0001 two cycles after accept, then 0010, 0100, 1000, 0001 every 4 cycles, each with a one-cycle step_pulse.
- COUNT running from 0 for 16 ticks -> led sequence 0..15 then wraps to 0000. Mid-run enable=0 for 10 cycles -> led and prescaler frozen, and stepping resumes with the same remaining count.
- BLINK running; cfg_valid with OFF asserted in the same cycle as a tick -> cfg_ready falls and led toggles once more. At the next tick the block goes to IDLE with led=0000, and cfg_ready=1 one cycle later.
- A second cfg_valid while cfg_ready=0 -> ignored, and only the first mode is applied. Re-selecting SHIFT while in SHIFT at led=0100 -> led reloads to 0001 via LOAD.
- rst pulse for one cycle during COUNT at led=0101 with a config pending -> next cycle led=0000, mode=OFF, cfg_ready=1, pending discarded.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// LED bank pattern sequencer: prescaled stepping of SHIFT/BLINK/COUNT patterns with a one-deep
// config handshake. Define LED_ACTIVE_LOW_EN to drive the LED pins inverted (active-low board).
module led_pattern_ctrl #(
  parameter int unsigned LED_W    = 4,
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [1:0]       cfg_mode,
  output logic             cfg_ready,
  output logic [LED_W-1:0] led,
  output logic             step_pulse,
  output logic [1:0]       mode
);

  localparam logic [1:0] ModeOff   = 2'b00;
  localparam logic [1:0] ModeShift = 2'b01;
  localparam logic [1:0] ModeBlink = 2'b10;
  localparam logic [1:0] ModeCount = 2'b11;

  localparam logic [CNT_W-1:0] TickMax = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [1:0]       pend_mode_q, pend_mode_d;
  logic [1:0]       mode_q, mode_d;
  logic [LED_W-1:0] pat_q, pat_d;
  logic             tick;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    mode_d      = mode_q;
    pat_d       = pat_q;
    step_pulse  = 1'b0;
    tick        = 1'b0;

    // Accept only when nothing is pending, so this never collides with a clear below.
    if (cfg_valid && !pend_q) begin
      pend_d      = 1'b1;
      pend_mode_d = cfg_mode;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        mode_d = ModeOff;
        pat_d  = '0;
        if (pend_q) begin
          if (pend_mode_q == ModeOff) pend_d = 1'b0;
          else                        state_d = StLoad;
        end
      end
      StLoad: begin
        mode_d  = pend_mode_q;
        pend_d  = 1'b0;
        cnt_d   = '0;
        state_d = StRun;
        unique case (pend_mode_q)
          ModeShift: pat_d = {{(LED_W-1){1'b0}}, 1'b1};
          ModeBlink: pat_d = '1;
          default:   pat_d = '0;
        endcase
      end
      StRun: begin
        if (enable) begin
          if (cnt_q == TickMax) begin
            cnt_d = '0;
            tick  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // A pending config takes the tick instead of a pattern step.
        if (tick) begin
          if (pend_q) begin
            if (pend_mode_q == ModeOff) begin
              state_d = StIdle;
              pat_d   = '0;
              mode_d  = ModeOff;
              pend_d  = 1'b0;
            end else begin
              state_d = StLoad;
            end
          end else begin
            step_pulse = 1'b1;
            unique case (mode_q)
              ModeShift: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
              ModeBlink: pat_d = ~pat_q;
              ModeCount: pat_d = pat_q + 1'b1;
              default:   pat_d = pat_q;
            endcase
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_mode_q <= ModeOff;
      mode_q      <= ModeOff;
      pat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      mode_q      <= mode_d;
      pat_q       <= pat_d;
    end
  end

  assign cfg_ready = ~pend_q;
  assign mode      = mode_q;

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~pat_q;
`else
  assign led = pat_q;
`endif

endmodule
